// File: rtl/r16_pipe_drain4_2.sv
// r16_pipe_drain4_2: applies the final radix-16 stage-4 correction R = Ac ? A0-N_D1 : A0 and buffers {R, D} in a FIFO with a valid/ready output and overflow reporting.
// Ports: clk, rst (async, active-high); in_valid/A0_in/Ac_in/N_in/D_in (non-stallable upstream bundle);
// out_valid/out_ready/R_out/D_out (downstream handshake); level (occupancy); ovf (sticky drop flag); ovf_clr (sync clear).
// Optional macro R16_DRAIN_OVF_CNT_EN adds ovf_cnt[15:0], a saturating count of dropped bundles.
module r16_pipe_drain4_2 #(
  parameter int P_WIDTH = 64,
  parameter int P_DEPTH = 4,
  parameter logic [P_WIDTH-1:0] P_ZERO = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [P_WIDTH-1:0]         A0_in,
  input  logic                       Ac_in,
  input  logic [P_WIDTH-1:0]         N_in,
  input  logic [P_WIDTH-1:0]         D_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [P_WIDTH-1:0]         R_out,
  output logic [P_WIDTH-1:0]         D_out,
  output logic [$clog2(P_DEPTH):0]   level,
  output logic                       ovf,
  input  logic                       ovf_clr
`ifdef R16_DRAIN_OVF_CNT_EN
  ,
  output logic [15:0]                ovf_cnt
`endif
);
  localparam int AW = $clog2(P_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = P_DEPTH[LW-1:0];
  logic [2*P_WIDTH-1:0] mem [P_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [P_WIDTH-1:0] corr;
  logic pop, push, drop;
  // A full FIFO still accepts a bundle when the head leaves in the same cycle.
  always_comb begin
    corr = Ac_in ? A0_in - N_in : A0_in;
    out_valid = level != '0;
    pop = out_valid & out_ready;
    push = in_valid & ((level < FULL) | pop);
    drop = in_valid & ~push;
    R_out = out_valid ? mem[rd_ptr][2*P_WIDTH-1:P_WIDTH] : P_ZERO;
    D_out = out_valid ? mem[rd_ptr][P_WIDTH-1:0] : P_ZERO;
  end
  // Storage needs no reset: an empty FIFO masks the head to P_ZERO.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {corr, D_in};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level <= '0;
      ovf <= 1'b0;
    end else begin
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      level <= level + LW'(push) - LW'(pop);
      ovf <= drop | (ovf & ~ovf_clr);
    end
`ifdef R16_DRAIN_OVF_CNT_EN
  // A drop coinciding with ovf_clr restarts the count at 1.
  always_ff @(posedge clk or posedge rst)
    if (rst) ovf_cnt <= '0;
    else ovf_cnt <= drop ? (ovf_clr ? 16'd1 : (&ovf_cnt ? ovf_cnt : ovf_cnt + 16'd1)) : (ovf_clr ? '0 : ovf_cnt);
`endif
endmodule
